// File: rtl/trojan_rx_pkg.sv
// rtl/trojan_rx_pkg.sv - shared types and defaults for the leak-stream receiver
package trojan_rx_pkg;
  localparam int WORD_W_DEF = 64;
  localparam int SYM_W_DEF  = 2;
  localparam int SYMS_DEF   = WORD_W_DEF / SYM_W_DEF;

  // Trigger pattern that arms the transmitter side of the harness
  localparam logic [31:0] TRIGGER = 32'h0044ab93;

  typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;
endpackage

// File: rtl/trojan_rx_deser.sv
// rtl/trojan_rx_deser.sv - LSB-first symbol shift register with frame position counter
module trojan_rx_deser
  import trojan_rx_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int SYM_W  = SYM_W_DEF,
  parameter int SYMS   = WORD_W / SYM_W,
  parameter int CW     = $clog2(SYMS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              shift_en,
  input  logic              clr,
  input  logic [SYM_W-1:0]  sym,
  output logic [WORD_W-1:0] sr,
  output logic              last_sym
);
  logic [CW-1:0]     r_cnt;
  logic [WORD_W-1:0] r_sr;

  assign sr       = r_sr;
  assign last_sym = shift_en && !clr && (r_cnt == CW'(SYMS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else begin
      if (shift_en) r_sr <= {sym, r_sr[WORD_W-1:SYM_W]};
      // Counter wraps to 0 on the last symbol so a back-to-back frame starts at 1
      if (clr)           r_cnt <= '0;
      else if (shift_en) r_cnt <= last_sym ? '0 : r_cnt + CW'(1);
    end
  end
endmodule

// File: rtl/trojan_rx_32_64.sv
// rtl/trojan_rx_32_64.sv - leak-stream receiver: frame FSM, word handshake, error flags
module trojan_rx_32_64
  import trojan_rx_pkg::*;
#(
  parameter int WORD_W  = WORD_W_DEF,
  parameter int SYM_W   = SYM_W_DEF,
  parameter int SYMS    = WORD_W / SYM_W,
  parameter int GAP_MAX = 0,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst_all,
  input  logic              leak_valid,
  input  logic [SYM_W-1:0]  leak_bits,
  output logic [WORD_W-1:0] key,
  output logic              key_valid,
  input  logic              key_ack,
  output logic              err_short,
  output logic              err_overrun,
  input  logic              clr_err,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic              busy
);
  localparam int GAP_W = $clog2(GAP_MAX + 2);

  state_t            r_state;
  logic [GAP_W-1:0]  r_gap;
  logic [WORD_W-1:0] r_key;
  logic              r_key_valid;
  logic              r_err_short;
  logic              r_err_overrun;
  logic [CNT_W-1:0]  r_frame_cnt;

  logic [WORD_W-1:0] w_sr;
  logic              w_last;
  logic              w_abort;

  assign w_abort = (r_state == RECV) && !leak_valid && (r_gap >= GAP_W'(GAP_MAX));

  trojan_rx_deser #(
    .WORD_W(WORD_W),
    .SYM_W (SYM_W),
    .SYMS  (SYMS)
  ) u_deser (
    .clk     (clk),
    .rst     (rst_all),
    .shift_en(leak_valid),
    .clr     (w_abort),
    .sym     (leak_bits),
    .sr      (w_sr),
    .last_sym(w_last)
  );

  always_ff @(posedge clk or posedge rst_all) begin
    if (rst_all) begin
      r_state       <= IDLE;
      r_gap         <= '0;
      r_key         <= '0;
      r_key_valid   <= 1'b0;
      r_err_short   <= 1'b0;
      r_err_overrun <= 1'b0;
      r_frame_cnt   <= '0;
    end else begin
      // Clear first so an error raised in the same cycle takes precedence
      if (clr_err) begin
        r_err_short   <= 1'b0;
        r_err_overrun <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          r_gap <= '0;
          if (leak_valid) r_state <= RECV;
        end
        RECV: begin
          if (leak_valid) begin
            r_gap <= '0;
            if (w_last) r_state <= DONE;
          end else if (w_abort) begin
            r_err_short <= 1'b1;
            r_gap       <= '0;
            r_state     <= IDLE;
          end else begin
            r_gap <= r_gap + GAP_W'(1);
          end
        end
        DONE: begin
          r_gap   <= '0;
          r_state <= leak_valid ? RECV : IDLE;
        end
        default: r_state <= IDLE;
      endcase

      if (r_state == DONE) begin
        r_key       <= w_sr;
        r_key_valid <= 1'b1;
        r_frame_cnt <= r_frame_cnt + CNT_W'(1);
        if (r_key_valid && !key_ack) r_err_overrun <= 1'b1;
      end else if (key_ack && r_key_valid) begin
        r_key_valid <= 1'b0;
      end
    end
  end

  assign key         = r_key;
  assign key_valid   = r_key_valid;
  assign err_short   = r_err_short;
  assign err_overrun = r_err_overrun;
  assign frame_cnt   = r_frame_cnt;
  assign busy        = (r_state == RECV);
endmodule

// File: doc/trojan_rx_32_64.md
Name: trojan_rx_32_64

Overview:
- Receive-side counterpart of the 32/64 key-leak transmitter.
- Samples the 2-bit-per-cycle leak stream (symbol + strobe), reassembles the 64-bit word and presents it on a valid/ack handshake.
- Flags short frames and unread-word overruns.
- Sits in the evaluation harness on the observation side of the leak channel. It is used to confirm the recovered word matches the data captured after the trigger.

Parameters:
- WORD_W, 64, reassembled word width.
- SYM_W, 2, bits per leak symbol.
- SYMS, 32, symbols per frame (WORD_W/SYM_W).
- GAP_MAX, 0, max consecutive idle cycles tolerated inside a frame before abort.
- CNT_W, 8, width of the good-frame counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_all  in  1  asynchronous active-high reset.
- leak_valid  in  1  symbol strobe (transmitter enable).
- leak_bits  in  SYM_W  leak symbol, sampled when leak_valid=1.
- key  out  WORD_W  last completed word.
- key_valid  out  1  key holds an unread word.
- key_ack  in  1  consumer accepts key; effective only while key_valid=1.
- err_short  out  1  sticky: frame aborted by gap.
- err_overrun  out  1  sticky: new word completed while previous word unread.
- clr_err  in  1  clears both sticky errors next edge.
- frame_cnt  out  CNT_W  count of good frames, wraps.
- busy  out  1  high in RECV state.

Behaviour:
- Reset (async, rst_all=1):
  - key=0, key_valid=0, err_short=0, err_overrun=0, frame_cnt=0, busy=0.
  - Shift register=0, symbol counter=0, gap counter=0, state=IDLE.
- Symbol order is LSB-first:
  - Each accepted symbol updates the shift register as sr <= {leak_bits, sr[WORD_W-1:SYM_W]}.
  - After SYMS symbols, the first symbol sits in sr[1:0] and the last in sr[63:62], reproducing the transmitted word bit-for-bit.
- FSM states:
  - IDLE:
    - leak_valid=1 → shift symbol, sym_cnt=1, go RECV.
    - leak_valid=0 → stay.
  - RECV, leak_valid=1:
    - Shift symbol, sym_cnt++, gap_cnt=0.
    - If this is symbol SYMS: go DONE, sym_cnt=0.
  - RECV, leak_valid=0:
    - gap_cnt++.
    - If gap_cnt would exceed GAP_MAX: err_short<=1, sym_cnt=0, gap_cnt=0, go IDLE.
    - Partial data is discarded; key is untouched.
  - DONE (one cycle):
    - key<=sr, key_valid<=1, frame_cnt++.
    - If key_valid=1 and key_ack=0 this cycle: err_overrun<=1 and key is overwritten.
    - If leak_valid=1 in DONE, that symbol is the first symbol of the next frame: shift it, sym_cnt=1, go RECV. Otherwise go IDLE.
- Latency: key_valid rises on the edge after the cycle of the 32nd symbol, i.e. 2 edges after the last symbol is sampled.
- Handshake:
  - key_ack with key_valid=1 → key_valid<=0 next edge.
  - key_ack with key_valid=0 is ignored.
  - DONE and key_ack in the same cycle → key_valid stays 1 with the new word; no overrun.
- frame_cnt wraps from 2^CNT_W-1 to 0.
- clr_err in the same cycle as a new error event: the error wins (flag set).
- rst_all mid-frame: immediate return to reset values; the partial frame is lost.
- busy=1 exactly while state=RECV.

Decomposition:
- Package trojan_rx_pkg:
  - State enum (IDLE, RECV, DONE).
  - Defaults for WORD_W, SYM_W, SYMS.
  - Trigger constant 32'h0044ab93 for bench use.
- Sub-module trojan_rx_deser:
  - Shift register and symbol counter, with shift_en and clr inputs and a last_sym output.
  - The FSM, handshake, error flags and frame counter stay in the top.

Test Plan:
- Nominal: 32 contiguous symbols encoding 64'h0123_4567_89AB_CDEF (first symbol 2'b11 = bits[1:0]) → key=64'h0123456789ABCDEF, key_valid=1 two edges after the last symbol, frame_cnt=1, no errors.
- Short frame: 20 symbols, then leak_valid=0 with GAP_MAX=0 → err_short=1 one edge later, state IDLE, key/key_valid unchanged. Next full frame is received correctly.
- Overrun: two back-to-back frames (64'hFFFF_0000_FFFF_0000 then 64'h1), key_ack held 0 → key=64'h1, err_overrun=1, frame_cnt=2. clr_err pulse → both errors 0.
- Ack collision: key_ack asserted in the DONE cycle of frame 2 while frame 1 is pending → key=frame 2, key_valid=1, err_overrun=0.
- Reset mid-frame: rst_all pulsed after 10 symbols (asynchronously, between edges) → all outputs 0 immediately. A subsequent 32-symbol frame of 64'hA5A5_A5A5_5A5A_5A5A is recovered exactly.
- Counter wrap: 256 good frames, each acked → frame_cnt returns to 0, no errors.
